bpf_sweep_scheduler: RTL
========================

Name: bpf_sweep_scheduler

Overview:
- Frequency-sweep controller for the 325 kHz bandpass-filter stage of the frequency-locking loop.
- Steps the excitation frequency word through N points. At each point it waits a settle window for the BPF to converge, then measures peak |BPF output| over a measurement window.
- Tracks the strongest response, then parks the frequency word at the best point as the coarse lock seed for the fine tracking loop.
- Runs on the filter's sample clock and consumes one filter output per cycle.

Parameters:
- SETTLE_LEN, 256, samples discarded after each frequency step; the filter pole radius is about 0.964, so tau is about 28 samples.
- MEAS_LEN, 1024, samples over which the peak is measured.
- FW, 32, frequency word width.

Ports:
- clk325kHz  input  1  sample clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a sweep; sampled only in IDLE.
- abort  input  1  terminates the sweep; returns to IDLE.
- f_start  input  FW  first frequency word.
- f_step  input  FW  frequency increment per point.
- n_steps  input  10  number of sweep points (0..1023).
- bpf_out  input  14 signed  current BPF output.
- freq_word  output  FW  frequency word driven to the excitation generator.
- busy  output  1  high from the start acceptance through the last UPDATE.
- done  output  1  one-cycle pulse at sweep completion.
- best_freq  output  FW  frequency word of the strongest point.
- best_amp  output  14 unsigned  peak |bpf_out| at best_freq.
- step_idx  output  10  index of the current point.

Behaviour:
- Reset: when rst=1 at a clock edge, all registers clear. Outputs become freq_word=0, busy=0, done=0, best_freq=0, best_amp=0, step_idx=0. State becomes IDLE. This applies mid-sweep; no partial result is retained. rst has priority over abort and start.
- IDLE, start=1, n_steps≠0:
  - Latch f_step and n_steps.
  - Set freq_word=f_start, best_freq=f_start, best_amp=0, step_idx=0, busy=1.
  - Clear the counter and go to SETTLE.
- IDLE, start=1, n_steps=0: go to DONE. best_freq=f_start, best_amp=0, and freq_word is unchanged.
- start is ignored in every state other than IDLE. f_start, f_step and n_steps are not re-read mid-sweep.
- SETTLE: count SETTLE_LEN cycles and ignore bpf_out. Then clear the peak register and go to MEASURE.
- MEASURE, per cycle:
  - peak = max(peak, |bpf_out|).
  - |x| is computed unsigned in 14 bits, so -8192 maps to 8192 with no saturation.
  - After MEAS_LEN cycles, go to UPDATE.
- UPDATE (exactly one cycle):
  - If peak > best_amp (strict), load best_amp=peak and best_freq=freq_word. On a tie, the earlier (lower-index) point is kept.
  - If step_idx = n_steps-1, go to DONE.
  - Otherwise set freq_word = freq_word + f_step, wrapping mod 2^FW, increment step_idx, and go to SETTLE.
- DONE (one cycle): done=1, busy=0, freq_word=best_freq, then go to IDLE.
  - Outputs hold in IDLE until the next start or reset.
- abort=1 in SETTLE, MEASURE or UPDATE: go to IDLE with busy=0 and no done pulse. freq_word, best_freq and best_amp hold their current values.
- abort and start together in IDLE: abort wins; the start is dropped.
- Timing: with the start edge as cycle 0, UPDATE for point k occurs at cycle (k+1)(SETTLE_LEN+MEAS_LEN+1)-1. done is high during cycle N(SETTLE_LEN+MEAS_LEN+1).
- Counters are sized to hold max(SETTLE_LEN, MEAS_LEN). Every output is registered.

Test Plan:
- Reset: assert rst mid-MEASURE -> next cycle all outputs are 0, state is IDLE, and no done pulse occurs.
- Sweep scenario (SETTLE_LEN=4, MEAS_LEN=8):
  - Setup: f_start=1000, f_step=100, n_steps=3. The bench drives a sinusoid with amplitude 100, 500 and 300 for freq_word 1000, 1100 and 1200 respectively.
  - Required: done at cycle 39, best_freq=1100, best_amp=500, freq_word=1100 after done.
  - Required: busy high for cycles 0..38.
- Tie: two points with equal peak 400 -> best_freq=f_start and best_amp=400.
- Abs boundary: bpf_out=-8192 during MEASURE -> best_amp=8192. Separately, bpf_out=+8191 -> best_amp=8191.
- Wrap: f_start=0xFFFFFFF0, f_step=0x20, n_steps=2 -> the second point's freq_word is 0x00000010.
- Control edges, each checked separately:
  - n_steps=0 -> done one cycle after start and best_amp=0.
  - start pulsed while busy -> ignored, with no timing shift.
  - abort in SETTLE -> busy=0, no done pulse, and freq_word holds its current value.

Source files
------------

// File: rtl/bpf_sweep_scheduler_if.sv
// Control and status bundle between the sweep scheduler and its host/filter.
// The master modport is the host side (drives commands and filter samples).
interface bpf_sweep_scheduler_if #(
  parameter int FW = 32
);
  logic                start;
  logic                abort;
  logic [FW-1:0]       f_start;
  logic [FW-1:0]       f_step;
  logic [9:0]          n_steps;
  logic signed [13:0]  bpf_out;
  logic [FW-1:0]       freq_word;
  logic                busy;
  logic                done;
  logic [FW-1:0]       best_freq;
  logic [13:0]         best_amp;
  logic [9:0]          step_idx;

  modport master (
    output start, abort, f_start, f_step, n_steps, bpf_out,
    input  freq_word, busy, done, best_freq, best_amp, step_idx
  );

  modport slave (
    input  start, abort, f_start, f_step, n_steps, bpf_out,
    output freq_word, busy, done, best_freq, best_amp, step_idx
  );
endinterface

// File: rtl/bpf_sweep_scheduler.sv
// Coarse frequency sweep: settle, measure peak |bpf_out|, keep the strongest point, park on it.
// N points take N*(SETTLE_LEN+MEAS_LEN+1) cycles; one filter sample consumed per cycle, no stall.
module bpf_sweep_scheduler #(
  parameter int SETTLE_LEN = 256,
  parameter int MEAS_LEN   = 1024,
  parameter int FW         = 32
) (
  input  logic clk325kHz,
  input  logic rst,
  bpf_sweep_scheduler_if.slave bus
);
  localparam int CMAX = (SETTLE_LEN > MEAS_LEN) ? SETTLE_LEN : MEAS_LEN;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE_LEN - 1);
  localparam logic [CW-1:0] M_LAST = CW'(MEAS_LEN - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, UPDATE, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [FW-1:0]  step_lat;
  logic [9:0]     n_lat;
  logic [13:0]    peak;
  logic [13:0]    abs_val;
  logic           last_pt;

  // Two's-complement magnitude kept at 14 bits: -8192 lands on 8192 unsaturated.
  assign abs_val = bus.bpf_out[13] ? (~$unsigned(bus.bpf_out) + 14'd1) : $unsigned(bus.bpf_out);
  assign last_pt = (bus.step_idx == n_lat - 10'd1);

  always_ff @(posedge clk325kHz) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && !bus.abort)
                 state_nxt = (bus.n_steps == 10'd0) ? DONE : SETTLE;
      SETTLE:  if (bus.abort)          state_nxt = IDLE;
               else if (cnt == S_LAST) state_nxt = MEASURE;
      MEASURE: if (bus.abort)          state_nxt = IDLE;
               else if (cnt == M_LAST) state_nxt = UPDATE;
      UPDATE:  if (bus.abort)          state_nxt = IDLE;
               else                    state_nxt = last_pt ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk325kHz) begin
    if (rst) begin
      cnt           <= '0;
      step_lat      <= '0;
      n_lat         <= '0;
      peak          <= '0;
      bus.freq_word <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.best_freq <= '0;
      bus.best_amp  <= '0;
      bus.step_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            step_lat      <= bus.f_step;
            n_lat         <= bus.n_steps;
            bus.best_freq <= bus.f_start;
            bus.best_amp  <= '0;
            bus.step_idx  <= '0;
            cnt           <= '0;
            if (bus.n_steps != 10'd0) begin
              bus.freq_word <= bus.f_start;
              bus.busy      <= 1'b1;
            end else begin
              bus.done      <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
          end else if (cnt == S_LAST) begin
            cnt  <= '0;
            peak <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
          end else begin
            if (abs_val > peak) peak <= abs_val;
            cnt <= (cnt == M_LAST) ? '0 : cnt + 1'b1;
          end
        end
        UPDATE: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
          end else begin
            // Strict compare: on a tie the lower-index point wins.
            if (peak > bus.best_amp) begin
              bus.best_amp  <= peak;
              bus.best_freq <= bus.freq_word;
            end
            if (last_pt) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              bus.freq_word <= bus.freq_word + step_lat;
              bus.step_idx  <= bus.step_idx + 10'd1;
              cnt           <= '0;
            end
          end
        end
        DONE: begin
          bus.done      <= 1'b0;
          bus.freq_word <= bus.best_freq;
        end
        default: ;
      endcase
    end
  end
endmodule
